// File: rtl/iq_symbol_modulator.sv
// Symbol-rate I/Q modulator: buffers signed I/Q symbols in a small FIFO, holds each for
// SYM_CYCLES clocks and mixes it with an fs/4 quadrature LO into an offset-binary DAC word.
module iq_symbol_modulator #(
  parameter int IQ_W       = 4,
  parameter int DAC_W      = 10,
  parameter int SYM_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             enable,
  input  logic             clr_flags,
  input  logic             sym_valid,
  input  logic [IQ_W-1:0]  sym_i,
  input  logic [IQ_W-1:0]  sym_q,
  output logic             sym_ready,
  output logic [DAC_W-1:0] dacval,
  output logic             busy,
  output logic             underrun,
  output logic [15:0]      sym_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CYC_W = $clog2(SYM_CYCLES);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SYM_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [DAC_W-1:0] DAC_MID  = {1'b1, {(DAC_W - 1){1'b0}}};
  localparam logic [IQ_W-1:0]  IQ_MIN   = {1'b1, {(IQ_W - 1){1'b0}}};
  localparam logic [IQ_W-1:0]  IQ_MAX   = {1'b0, {(IQ_W - 1){1'b1}}};
  localparam logic [IQ_W-1:0]  IQ_ONE   = IQ_W'(1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Two's-complement negate that clips the most negative code to the most positive one.
  function automatic logic [IQ_W-1:0] neg_sat(input logic [IQ_W-1:0] v);
    if (v == IQ_MIN) return IQ_MAX;
    return ~v + IQ_ONE;
  endfunction

  // MID + v*2^(DAC_W-IQ_W) is the left-aligned value with its sign bit inverted.
  function automatic logic [DAC_W-1:0] to_dac(input logic [IQ_W-1:0] v);
    return {~v[IQ_W-1], v[IQ_W-2:0], {(DAC_W - IQ_W){1'b0}}};
  endfunction

  // ---------------------------------------------------------------- symbol FIFO
  logic [2*IQ_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop;
  logic [IQ_W-1:0]   head_i, head_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = sym_valid && !fifo_full;
  assign head_i     = mem_q[rd_ptr_q[PTR_W-1:0]][2*IQ_W-1:IQ_W];
  assign head_q     = mem_q[rd_ptr_q[PTR_W-1:0]][IQ_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: storage is not reset; the pointers define validity, so a reset flushes the FIFO anyway.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {sym_i, sym_q};
  end

  // ---------------------------------------------------------------- sequencer
  logic             state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [IQ_W-1:0]  i_hold_q, i_hold_d;
  logic [IQ_W-1:0]  q_hold_q, q_hold_d;
  logic [15:0]      sym_count_q, sym_count_d;
  logic             underrun_q, underrun_d;
  logic [DAC_W-1:0] dacval_q, dacval_d;
  logic [IQ_W-1:0]  mix_val;
  logic             underrun_set;

  // LO multiply by cos/sin = (1,0,-1,0)/(0,1,0,-1) reduces to selecting +I,+Q,-I,-Q.
  always_comb begin
    mix_val = i_hold_q;
    case (phase_q)
      2'd0:    mix_val = i_hold_q;
      2'd1:    mix_val = q_hold_q;
      2'd2:    mix_val = neg_sat(i_hold_q);
      default: mix_val = neg_sat(q_hold_q);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cyc_d        = cyc_q;
    i_hold_d     = i_hold_q;
    q_hold_d     = q_hold_q;
    sym_count_d  = sym_count_q;
    dacval_d     = DAC_MID;
    pop          = 1'b0;
    underrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = 2'd0;
        cyc_d   = '0;
        if (enable && !fifo_empty) begin
          pop         = 1'b1;
          i_hold_d    = head_i;
          q_hold_d    = head_q;
          sym_count_d = sym_count_q + 16'd1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        dacval_d = to_dac(mix_val);
        phase_d  = phase_q + 2'd1;
        cyc_d    = cyc_q + CYC_ONE;
        // The running symbol always completes; the decision is taken only on its last clock.
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (enable && !fifo_empty) begin
            pop         = 1'b1;
            i_hold_d    = head_i;
            q_hold_d    = head_q;
            sym_count_d = sym_count_q + 16'd1;
          end else begin
            underrun_set = enable;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (underrun_set)   underrun_d = 1'b1;
    else if (clr_flags) underrun_d = 1'b0;
    else                underrun_d = underrun_q;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      cyc_q       <= '0;
      i_hold_q    <= '0;
      q_hold_q    <= '0;
      sym_count_q <= 16'd0;
      underrun_q  <= 1'b0;
      dacval_q    <= DAC_MID;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      cyc_q       <= cyc_d;
      i_hold_q    <= i_hold_d;
      q_hold_q    <= q_hold_d;
      sym_count_q <= sym_count_d;
      underrun_q  <= underrun_d;
      dacval_q    <= dacval_d;
    end
  end

  assign sym_ready = !fifo_full;
  assign dacval    = dacval_q;
  assign busy      = (state_q == ST_RUN);
  assign underrun  = underrun_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_iq_symbol_modulator.sv
// Bench for iq_symbol_modulator: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a symbol-level model held in queues.
module tb_iq_symbol_modulator;

  localparam int IQ_W  = 4;
  localparam int DAC_W = 10;
  localparam int SYM   = 16;
  localparam int DEPTH = 4;
  localparam int MID   = 1 << (DAC_W - 1);
  localparam int STEP  = 1 << (DAC_W - IQ_W);
  localparam int VMAX  = (1 << (IQ_W - 1)) - 1;

  logic             clk = 1'b0;
  logic             areset_n = 1'b0;
  logic             enable = 1'b0;
  logic             clr_flags = 1'b0;
  logic             sym_valid = 1'b0;
  logic [IQ_W-1:0]  sym_i = '0;
  logic [IQ_W-1:0]  sym_q = '0;
  logic             sym_ready;
  logic [DAC_W-1:0] dacval;
  logic             busy;
  logic             underrun;
  logic [15:0]      sym_count;

  int n_checks = 0;
  int n_fail   = 0;

  iq_symbol_modulator #(
    .IQ_W(IQ_W), .DAC_W(DAC_W), .SYM_CYCLES(SYM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .areset_n(areset_n), .enable(enable), .clr_flags(clr_flags),
    .sym_valid(sym_valid), .sym_i(sym_i), .sym_q(sym_q), .sym_ready(sym_ready),
    .dacval(dacval), .busy(busy), .underrun(underrun), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int scale(input int v);
    return MID + v * STEP;
  endfunction

  function automatic int sat_neg(input int v);
    return (-v > VMAX) ? VMAX : -v;
  endfunction

  // ---------------------------------------------------------------- reference model
  int mq_i[$];
  int mq_q[$];
  bit m_run = 0;
  int m_pos = 0;
  int m_i = 0;
  int m_q = 0;
  int m_dac = MID;
  int m_cnt = 0;
  bit m_und = 0;

  always begin
    int  nxt_dac;
    bit  can_push;
    bit  start;
    bit  und_set;
    @(posedge clk);
    if (!areset_n) begin
      mq_i.delete();
      mq_q.delete();
      m_run = 0; m_pos = 0; m_i = 0; m_q = 0;
      m_dac = MID; m_cnt = 0; m_und = 0;
    end else begin
      can_push = mq_i.size() < DEPTH;
      nxt_dac  = MID;
      start    = 0;
      und_set  = 0;
      if (m_run) begin
        // The LO index is simply the position within the symbol modulo 4.
        case (m_pos % 4)
          0: nxt_dac = scale(m_i);
          1: nxt_dac = scale(m_q);
          2: nxt_dac = scale(sat_neg(m_i));
          default: nxt_dac = scale(sat_neg(m_q));
        endcase
        if (m_pos == SYM - 1) begin
          if (enable && mq_i.size() > 0) start = 1;
          else begin
            und_set = enable;
            m_run   = 0;
          end
        end else begin
          m_pos++;
        end
      end else if (enable && mq_i.size() > 0) begin
        start = 1;
      end
      if (start) begin
        m_i   = mq_i.pop_front();
        m_q   = mq_q.pop_front();
        m_pos = 0;
        m_run = 1;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (und_set) m_und = 1;
      else if (clr_flags) m_und = 0;
      if (sym_valid && can_push) begin
        mq_i.push_back(int'($signed(sym_i)));
        mq_q.push_back(int'($signed(sym_q)));
      end
      m_dac = nxt_dac;
    end
    #1;
    check("cmp_dacval", int'(dacval), m_dac);
    check("cmp_busy", int'(busy), int'(m_run));
    check("cmp_sym_ready", int'(sym_ready), int'(mq_i.size() < DEPTH));
    check("cmp_underrun", int'(underrun), int'(m_und));
    check("cmp_sym_count", int'(sym_count), m_cnt);
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_sym(input int i, input int q);
    sym_valid = 1'b1;
    sym_i     = i[IQ_W-1:0];
    sym_q     = q[IQ_W-1:0];
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic wait_busy(input bit val, input int budget, input string name, output int n);
    n = 0;
    while (busy !== val && n < budget) begin
      tick();
      n++;
    end
    if (busy !== val) check(name, int'(busy), int'(val));
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    clr_flags = 1'b0;
    sym_valid = 1'b0;
    areset_n  = 1'b0;
    tick();
    areset_n  = 1'b1;
    tick();
  endtask

  int exp2 [4] = '{960, 320, 64, 704};
  int exp3a[4] = '{576, 576, 448, 448};
  int exp3b[4] = '{0, 512, 960, 512};

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Pin the model's arithmetic to hand-computed DAC codes.
    check("pin_scale_min", scale(-8), 0);
    check("pin_scale_zero", scale(0), 512);
    check("pin_scale_max", scale(7), 960);
    check("pin_neg_sat", scale(sat_neg(-8)), 960);

    // 1: reset values, then an asynchronous reset in the middle of a symbol.
    tick();
    tick();
    check("rst_dacval", int'(dacval), 512);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(sym_ready), 1);
    check("rst_count", int'(sym_count), 0);
    check("rst_underrun", int'(underrun), 0);
    areset_n = 1'b1;
    tick();
    push_sym(3, -4);
    push_sym(-2, 5);
    enable = 1'b1;
    wait_busy(1, 10, "t1_start_timeout", n);
    repeat (6) tick();
    areset_n = 1'b0;
    #1;
    check("t1_async_dacval", int'(dacval), 512);
    check("t1_async_busy", int'(busy), 0);
    check("t1_async_ready", int'(sym_ready), 1);
    check("t1_async_count", int'(sym_count), 0);
    enable = 1'b0;
    tick();
    areset_n = 1'b1;
    tick();

    // 2: single symbol I=7, Q=-3, then underrun.
    do_reset();
    enable = 1'b1;
    push_sym(7, -3);
    wait_busy(1, 10, "t2_start_timeout", n);
    for (int k = 0; k < SYM; k++) begin
      tick();
      check("t2_dacval", int'(dacval), exp2[k % 4]);
    end
    tick();
    check("t2_idle_dacval", int'(dacval), 512);
    check("t2_idle_busy", int'(busy), 0);
    check("t2_underrun", int'(underrun), 1);

    // 3: back-to-back symbols, second one exercises saturated negation.
    do_reset();
    push_sym(1, 1);
    push_sym(-8, 0);
    enable = 1'b1;
    wait_busy(1, 10, "t3_start_timeout", n);
    for (int k = 0; k < 2 * SYM; k++) begin
      tick();
      check("t3_dacval", int'(dacval), (k < SYM) ? exp3a[k % 4] : exp3b[k % 4]);
      if (k == SYM) check("t3_no_gap_busy", int'(busy), 1);
    end
    tick();
    check("t3_idle_dacval", int'(dacval), 512);
    check("t3_count", int'(sym_count), 2);

    // 4: backpressure with enable low, then exactly four symbols play.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sym_valid = 1'b1;
      sym_i     = IQ_W'($urandom);
      sym_q     = IQ_W'($urandom);
      tick();
      if (k == 3) check("t4_ready_full", int'(sym_ready), 0);
    end
    sym_valid = 1'b0;
    check("t4_count_idle", int'(sym_count), 0);
    enable = 1'b1;
    wait_busy(1, 10, "t4_start_timeout", n);
    wait_busy(0, 4 * SYM + 8, "t4_end_timeout", n);
    check("t4_count", int'(sym_count), 4);
    check("t4_ready_empty", int'(sym_ready), 1);
    check("t4_underrun", int'(underrun), 1);

    // 5: enable dropped at cyc=5; symbol completes, queued entries retained.
    do_reset();
    push_sym(2, -1);
    push_sym(-5, 6);
    push_sym(4, -8);
    enable = 1'b1;
    wait_busy(1, 10, "t5_start_timeout", n);
    repeat (5) tick();
    enable = 1'b0;
    wait_busy(0, SYM + 4, "t5_end_timeout", n);
    check("t5_finish_delay", n, SYM - 5);
    check("t5_underrun", int'(underrun), 0);
    check("t5_count", int'(sym_count), 1);
    enable = 1'b1;
    wait_busy(1, 10, "t5_restart_timeout", n);
    wait_busy(0, 2 * SYM + 8, "t5_drain_timeout", n);
    check("t5_count_drained", int'(sym_count), 3);

    // 6: underrun set wins over a simultaneous clr_flags; cleared next clock.
    do_reset();
    clr_flags = 1'b1;
    enable    = 1'b1;
    push_sym(3, -2);
    wait_busy(1, 10, "t6_start_timeout", n);
    wait_busy(0, SYM + 4, "t6_end_timeout", n);
    check("t6_underrun_set", int'(underrun), 1);
    tick();
    check("t6_underrun_clr", int'(underrun), 0);
    clr_flags = 1'b0;

    // Randomized traffic; the model process checks every cycle.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      sym_valid = ($urandom_range(0, 99) < 35);
      sym_i     = IQ_W'($urandom);
      sym_q     = IQ_W'($urandom);
      if ($urandom_range(0, 99) < 4) enable = ~enable;
      clr_flags = ($urandom_range(0, 99) < 5);
      tick();
    end
    sym_valid = 1'b0;
    enable    = 1'b0;
    clr_flags = 1'b0;
    repeat (SYM + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
